multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port OP, input, 6: opcode from instruction register.
REQ-004 SHALL have port func, input, 6: R-type function field from instruction register.
REQ-005 SHALL have port Zero, input, 1: ALU zero flag.
REQ-006 SHALL have port MemRdy, input, 1: memory completes current request this cycle.
REQ-007 SHALL have port MemReq, output, 1: memory access request.
REQ-008 SHALL have port IorD, output, 1: memory address select (0 PC, 1 ALUOut).
REQ-009 SHALL have outputs MemWr, IRWr, PCWr and RegWr, each 1 bit: write enables.
REQ-010 SHALL have outputs RegDst, MemtoReg, ALUSrcA and ExtOp, each 1 bit: datapath selects.
REQ-011 SHALL have output PCSrc, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 SHALL have output ALUSrcB, 2 bits: 00 reg B, 01 constant 4, 10 extended imm, 11 extended imm<<2.
REQ-013 SHALL have output ALUctr, 3 bits: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-014 SHALL have output state, 3 bits: current state; IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-015 SHALL have output Illegal, 1 bit: one-cycle pulse on an unsupported instruction.

Function
REQ-016 SHALL support R-type (OP 000000; func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, j 000010, addi 001000 and ori 001101.
REQ-017 SHALL register only state; all outputs decode combinationally from state, OP, func, Zero and MemRdy; unlisted outputs are 0 and ALUctr defaults to 000.
REQ-018 IF: SHALL drive MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=add; stay in IF while MemRdy=0; when MemRdy=1, SHALL assert IRWr=1, PCWr=1 and PCSrc=00, then go to ID.
REQ-019 ID: SHALL drive ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=add (branch target to ALUOut).
REQ-020 ID, j: SHALL assert PCWr=1 with PCSrc=10, then go to IF.
REQ-021 ID, unsupported OP or R-type func: SHALL assert Illegal=1 and go to IF with no write enable asserted; otherwise go to EX.
REQ-022 EX, R-type: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUctr per func, then go to WB.
REQ-023 EX, addi/ori: SHALL drive ALUSrcA=1, ALUSrcB=10; addi: ExtOp=1, add; ori: ExtOp=0, or; then go to WB.
REQ-024 EX, lw/sw: SHALL drive ALUSrcA=1, ALUSrcB=10, ExtOp=1, add, then go to MEM.
REQ-025 EX, beq: SHALL drive ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01 and PCWr=Zero, then go to IF.
REQ-026 MEM: SHALL drive MemReq=1, IorD=1, and MemWr=1 for sw, held for every wait cycle; stay in MEM while MemRdy=0; on MemRdy=1, sw goes to IF and lw goes to WB.
REQ-027 WB: SHALL assert RegWr=1 with RegDst=1 for R-type (else 0) and MemtoReg=1 for lw (else 0), then go to IF.
REQ-028 SHALL ignore MemRdy outside IF and MEM.
REQ-029 With zero wait states, cycle counts SHALL be: j 2, beq 3, R/addi/ori/sw 4, lw 5; each MemRdy=0 cycle adds one.
REQ-030 Encodings 5-7 of state SHALL be unreachable; if entered they SHALL go to IF on the next edge.

Reset
REQ-031 rst=1 SHALL force state to IF immediately, independent of clk.
REQ-032 While rst=1 all outputs SHALL be 0, including MemReq, and state SHALL read 0.
REQ-033 rst asserted mid-instruction (including MEM wait) SHALL abandon the instruction; the first IF fetch SHALL begin on the first rising edge after rst falls.

Configuration
REQ-034 With macro PERF_CNT_EN defined, the block SHALL add outputs cycle_cnt (32 bits, increments every cycle rst=0) and instr_cnt (32 bits, increments on each transition into IF from ID, EX, MEM or WB); both clear to 0 on rst and wrap at 2^32-1 to 0.
REQ-035 Without PERF_CNT_EN, those ports and registers SHALL not exist and behaviour SHALL otherwise be identical.

Verification
REQ-036 Bench SHALL cover: OP=000000, func=100010, MemRdy=1 -> states 0,1,2,4,0; ALUctr=001 in EX; RegWr=1 and RegDst=1 in WB.
REQ-037 Bench SHALL cover: lw, MemRdy low 2 cycles in MEM -> MEM held 3 cycles with MemReq=1 and IorD=1, then WB with MemtoReg=1; total 7 cycles.
REQ-038 Bench SHALL cover: beq with Zero=1 -> PCWr=1, PCSrc=01 in EX; with Zero=0 -> PCWr=0; both return to IF after 3 cycles.
REQ-039 Bench SHALL cover: OP=111111 -> Illegal=1 for exactly one cycle in ID, no write enable asserted, next state IF.
REQ-040 Bench SHALL cover: rst pulsed between clock edges during EX of sw -> state=0 and all outputs 0 before the next edge; MemWr never asserted.
REQ-041 Bench SHALL cover, with PERF_CNT_EN: 10 j instructions from reset -> instr_cnt=10, cycle_cnt=20.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: five-state multi-cycle MIPS-subset control FSM (IF, ID, EX, MEM, WB)
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   OP, func, Zero    opcode, R-type function field, ALU zero flag
//   MemRdy            memory completes the current request this cycle
//   MemReq, IorD      memory request and address select (0 PC, 1 ALUOut)
//   MemWr, IRWr, PCWr, RegWr               write enables
//   RegDst, MemtoReg, ALUSrcA, ExtOp       datapath selects
//   PCSrc, ALUSrcB, ALUctr                 multi-bit datapath selects
//   state             current state (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   Illegal           one-cycle pulse in ID on an unsupported instruction
//   cycle_cnt, instr_cnt  performance counters, present only with PERF_CNT_EN defined
module multi_cycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  OP,
    input  logic [5:0]  func,
    input  logic        Zero,
    input  logic        MemRdy,
    output logic        MemReq,
    output logic        IorD,
    output logic        MemWr,
    output logic        IRWr,
    output logic        PCWr,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        ExtOp,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUctr,
    output logic [2:0]  state,
`ifdef PERF_CNT_EN
    output logic        Illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`else
    output logic        Illegal
`endif
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t     state_q, state_d;
    logic       is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_ori;
    logic       r_ok, legal;
    logic [2:0] r_alu;

    assign is_r    = OP == OP_R;
    assign is_lw   = OP == OP_LW;
    assign is_sw   = OP == OP_SW;
    assign is_beq  = OP == OP_BEQ;
    assign is_j    = OP == OP_J;
    assign is_addi = OP == OP_ADDI;
    assign is_ori  = OP == OP_ORI;

    assign r_ok  = func inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign r_alu = (func == F_SUB) ? ALU_SUB :
                   (func == F_AND) ? ALU_AND :
                   (func == F_OR)  ? ALU_OR  :
                   (func == F_SLT) ? ALU_SLT : ALU_ADD;
    // j is resolved in ID on its own, so it is not part of the "goes to EX" set
    assign legal = (is_r && r_ok) || is_lw || is_sw || is_beq || is_addi || is_ori;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    assign state = state_q;

    // Outputs are forced low while rst is high, so IF's MemReq does not leak out during reset
    always_comb begin
        state_d  = state_q;
        MemReq   = 1'b0;
        IorD     = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ExtOp    = 1'b0;
        PCSrc    = 2'b00;
        ALUSrcB  = 2'b00;
        ALUctr   = ALU_ADD;
        Illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    MemReq  = 1'b1;
                    ALUSrcB = 2'b01;
                    if (MemRdy) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    // branch target is computed here speculatively into ALUOut
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    if (is_j) begin
                        PCWr    = 1'b1;
                        PCSrc   = 2'b10;
                        state_d = S_IF;
                    end else if (!legal) begin
                        Illegal = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_EX;
                    end
                end
                S_EX: begin
                    ALUSrcA = 1'b1;
                    state_d = S_WB;
                    if (is_r) begin
                        ALUctr = r_alu;
                    end else if (is_beq) begin
                        ALUctr  = ALU_SUB;
                        PCSrc   = 2'b01;
                        PCWr    = Zero;
                        state_d = S_IF;
                    end else begin
                        ALUSrcB = 2'b10;
                        ExtOp   = !is_ori;
                        ALUctr  = is_ori ? ALU_OR : ALU_ADD;
                        state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                    MemWr  = is_sw;
                    if (MemRdy) state_d = is_sw ? S_IF : S_WB;
                end
                S_WB: begin
                    RegWr    = 1'b1;
                    RegDst   = is_r;
                    MemtoReg = is_lw;
                    state_d  = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (state_d == S_IF && state_q != S_IF) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed self-checking bench for multi_cycle_controller
module tb_multi_cycle_controller;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2b;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] J    = 6'h02;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] ORI  = 6'h0d;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, iord, mwr, irwr, pcwr, regwr, regdst, m2r, asa, ext;
        logic [1:0] pcsrc, asb;
        logic [2:0] alu;
        logic       ill;
    } out_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [5:0] OP = '0, func = '0;
    logic       Zero = 1'b0, MemRdy = 1'b0;
    logic       MemReq, IorD, MemWr, IRWr, PCWr, RegWr, RegDst, MemtoReg, ALUSrcA, ExtOp, Illegal;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUctr, state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk(clk), .rst(rst), .OP(OP), .func(func), .Zero(Zero), .MemRdy(MemRdy),
        .MemReq(MemReq), .IorD(IorD), .MemWr(MemWr), .IRWr(IRWr), .PCWr(PCWr),
        .RegWr(RegWr), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ExtOp(ExtOp), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr),
        .state(state),
`ifdef PERF_CNT_EN
        .Illegal(Illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`else
        .Illegal(Illegal)
`endif
    );

    out_t dut_o, exp_o;
    assign dut_o = {state, MemReq, IorD, MemWr, IRWr, PCWr, RegWr, RegDst, MemtoReg,
                    ALUSrcA, ExtOp, PCSrc, ALUSrcB, ALUctr, Illegal};

    int   checks = 0, errors = 0, cyc = 0;
    bit   chk = 0, rec = 0, mwr_seen = 0;
    out_t obs[$];

    always @(posedge MemWr) mwr_seen = 1;

    always @(negedge clk) begin
        cyc++;
        if (chk) begin
            if (rec) obs.push_back(dut_o);
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL cycle %0d outputs: got %h expected %h", cyc, dut_o, exp_o);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step(input out_t e, input logic rdy);
        MemRdy = rdy;
        exp_o  = e;
        chk    = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic out_t if_out(input bit fire);
        out_t e;
        e = '0;
        e.mreq = 1;
        e.asb = 2'b01;
        e.irwr = fire;
        e.pcwr = fire;
        return e;
    endfunction

    // Expected micro-step listing for one instruction, derived from its class
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int ifw, input int memw);
        out_t e;
        bit r, r_ok;
        logic [2:0] ra;
        OP = op; func = fn; Zero = z;
        obs.delete();
        rec = 1;
        for (int i = 0; i < ifw; i++) step(if_out(0), 0);
        step(if_out(1), 1);
        r = op == 6'h00;
        r_ok = 1;
        ra = 3'd0;
        case (fn)
            6'h20: ra = 3'd0;
            6'h22: ra = 3'd1;
            6'h24: ra = 3'd2;
            6'h25: ra = 3'd3;
            6'h2a: ra = 3'd4;
            default: r_ok = 0;
        endcase
        e = '0; e.st = 3'd1; e.asb = 2'b11; e.ext = 1;
        if (op == J) begin
            e.pcwr = 1; e.pcsrc = 2'b10;
            step(e, 0);
        end else if (!((r && r_ok) || op inside {LW, SW, BEQ, ADDI, ORI})) begin
            e.ill = 1;
            step(e, 1);
        end else begin
            step(e, 1);
            e = '0; e.st = 3'd2; e.asa = 1;
            if (op == BEQ) begin
                e.alu = 3'd1; e.pcsrc = 2'b01; e.pcwr = z;
                step(e, 1);
            end else begin
                if (r) e.alu = ra;
                else begin
                    e.asb = 2'b10; e.ext = op != ORI; e.alu = (op == ORI) ? 3'd3 : 3'd0;
                end
                step(e, 1);
                if (op == LW || op == SW) begin
                    e = '0; e.st = 3'd3; e.mreq = 1; e.iord = 1; e.mwr = op == SW;
                    for (int i = 0; i < memw; i++) step(e, 0);
                    step(e, 1);
                end
                if (op != SW) begin
                    e = '0; e.st = 3'd4; e.regwr = 1; e.regdst = r; e.m2r = op == LW;
                    step(e, 0);
                end
            end
        end
        rec = 0;
    endtask

    initial begin
        out_t e;
        #12;
        check("rst_state", {29'd0, state}, 0);
        check("rst_outs", {11'd0, dut_o}, 0);
        MemRdy = 1;
        #1 check("rst_outs_rdy", {11'd0, dut_o}, 0);
        @(posedge clk); #1;
        rst = 0;

        run(6'h00, 6'h22, 0, 0, 0);
        check("rsub_len", obs.size(), 4);
        check("rsub_states", {obs[0].st, obs[1].st, obs[2].st, obs[3].st, state}, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
        check("rsub_ex_alu", {29'd0, obs[2].alu}, 1);
        check("rsub_wb", {obs[3].regwr, obs[3].regdst}, 2'b11);

        run(LW, 6'h00, 0, 0, 2);
        check("lw_len", obs.size(), 7);
        check("lw_mem_hold", {obs[3].st, obs[4].st, obs[5].st}, {3'd3, 3'd3, 3'd3});
        check("lw_mem_req", {obs[3].mreq, obs[3].iord, obs[5].mreq, obs[5].iord}, 4'hf);
        check("lw_wb", {obs[6].st, obs[6].m2r, obs[6].regwr}, {3'd4, 1'b1, 1'b1});
        check("lw_ret", {29'd0, state}, 0);

        run(BEQ, 6'h00, 1, 0, 0);
        check("beq1_len", obs.size(), 3);
        check("beq1_ex", {obs[2].pcwr, obs[2].pcsrc}, 3'b101);
        run(BEQ, 6'h00, 0, 0, 0);
        check("beq0_len", obs.size(), 3);
        check("beq0_pcwr", obs[2].pcwr, 0);
        check("beq0_ret", {29'd0, state}, 0);

        run(6'h3f, 6'h00, 0, 0, 0);
        check("ill_len", obs.size(), 2);
        check("ill_pulse", obs[1].ill, 1);
        check("ill_we", {obs[1].mwr, obs[1].irwr, obs[1].pcwr, obs[1].regwr}, 0);
        check("ill_next", {28'd0, state, Illegal}, 0);

        run(6'h00, 6'h00, 0, 0, 0);
        run(6'h00, 6'h20, 0, 1, 0);
        run(6'h00, 6'h24, 0, 0, 0);
        run(6'h00, 6'h25, 0, 0, 0);
        run(6'h00, 6'h2a, 0, 2, 0);
        run(ADDI, 6'h00, 0, 0, 0);
        run(ORI, 6'h00, 0, 0, 0);
        run(SW, 6'h00, 0, 0, 1);
        check("sw_len", obs.size(), 5);
        run(J, 6'h00, 0, 0, 0);
        check("j_len", obs.size(), 2);

        OP = SW; func = 6'h00;
        step(if_out(1), 1);
        e = '0; e.st = 3'd1; e.asb = 2'b11; e.ext = 1;
        step(e, 1);
        chk = 0;
        mwr_seen = 0;
        MemRdy = 0;
        check("sw_in_ex", {29'd0, state}, 2);
        #2 rst = 1;
        #1;
        check("rst_ex_state", {29'd0, state}, 0);
        check("rst_ex_outs", {11'd0, dut_o}, 0);
        @(posedge clk); #1;
        check("rst_hold_outs", {11'd0, dut_o}, 0);
        #2 rst = 0;
        #1;
        check("rst_rel_if", {11'd0, dut_o}, {11'd0, if_out(0)});
        check("sw_no_memwr", mwr_seen, 0);
        run(J, 6'h00, 0, 0, 0);
        run(6'h00, 6'h22, 0, 0, 0);

`ifdef PERF_CNT_EN
        chk = 0;
        #2 rst = 1;
        @(posedge clk); #1;
        check("perf_clr_cyc", cycle_cnt, 0);
        check("perf_clr_ins", instr_cnt, 0);
        rst = 0;
        for (int i = 0; i < 10; i++) run(J, 6'h00, 0, 0, 0);
        check("perf_instr", instr_cnt, 10);
        check("perf_cycle", cycle_cnt, 20);
`endif

        chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
